bcd_to_binary_32bits: RTL and testbench
=======================================

// Module: bcd_to_binary_32bits
// PURPOSE
//  Iterative BCD-to-binary converter (reverse double-dabble); inverse of the 32-bit binary-to-BCD path.
//  Takes 11 packed BCD digits (up to 4294967295) and returns a 32-bit binary value.
//  Sits between the keypad/display digit registers and the multiplier/divisor/square-root operand inputs.
//  Uses a start/done handshake and one shift per clock.
// PARAMETERS
//  NUM_DIGITS  11  number of BCD digits accepted (digit 1 = least significant)
//  BIN_WIDTH   32  binary result width = number of shift iterations
// PORTS
//  clk       in   1   system clock, rising edge
//  reset     in   1   asynchronous, active-low reset
//  start     in   1   request conversion; sampled only in IDLE
//  in1..in11 in   4   BCD digits, in1 = units ... in11 = 10^10
//  bin_out   out  32  binary result; holds until next completion
//  busy      out  1   high from accepted start until done
//  done      out  1   one-cycle pulse when bin_out/flags are valid
//  error     out  1   a digit was >9 at load; valid with done, held until next start
//  overflow  out  1   BCD value >2^32-1; valid with done, held until next start
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE; bin_out=0; busy=0; done=0; error=0; overflow=0; internal registers cleared.
//  Reset deasserted mid-conversion: the conversion is abandoned. No done is produced.
//  States: IDLE -> SHIFT -> DONE -> IDLE. INVALID path: IDLE -> DONE.
//  IDLE: on an edge with start=1:
//   - latch the 44-bit digit vector {in11..in1} into bcd_reg
//   - clear bin_reg, cnt=0, error=0, overflow=0
//   - if any digit >9: error=1, bin_out=0, go to DONE (done seen 1 cycle after the start edge)
//   - otherwise busy=1, go to SHIFT
//  SHIFT: each edge does one step:
//   - {bcd_reg,bin_reg} >>= 1, with a 0 entering the MSB
//   - then every 4-bit digit of the shifted bcd_reg that is >=8 has 3 subtracted (all digits in parallel, same cycle)
//   - cnt++
//  On the edge where cnt==BIN_WIDTH-1 (the 32nd shift):
//   - bin_out<=shifted bin_reg
//   - overflow<=(corrected bcd_reg!=0)
//   - busy<=0, go to DONE
//  Latency: done is high in the cycle after the 32nd shift edge, i.e. 32 clocks after the start edge.
//  DONE: done=1 for exactly one cycle, then IDLE. A start during DONE is ignored.
//  start while busy or in DONE: ignored. Inputs are not re-sampled; changing inN mid-conversion has no effect.
//  Back-to-back: start held high re-triggers in the first IDLE cycle after DONE (throughput 1 per 34 clocks).
//  On overflow, bin_out = low 32 bits of the true value (modulo 2^32) and overflow=1.
//  Widths:
//   - bcd_reg is 4*NUM_DIGITS bits; cnt is $clog2(BIN_WIDTH) bits, no wrap within one conversion
//   - subtract-3 never underflows, because a digit >=8 stays >=5
// STRUCTURE
//  Shared package: state enum (IDLE, SHIFT, DONE), BCD_DIGIT_W=4, BCD_MAX_DIGIT=4'd9, BCD_CORR=4'd3.
//  Shared package: typedef for the packed 44-bit BCD word, shared with the binary-to-BCD path.
//  Sub-module bcd_digit_sub3: combinational 4-bit in/out.
//   - out = (in>=8) ? in-3 : in
//   - inverse of the add-3 cell; NUM_DIGITS instances in a generate loop
//  Top level: FSM + counter + shift registers only.
// TESTING
//  1. reset low, then release -> all outputs 0; start with digits 0 -> done at +32 clk, bin_out=0, error=0, overflow=0.
//  2. digits 12345 -> done exactly 32 clk after the start edge, bin_out=32'h00003039, busy high for 32 cycles.
//  3. digits 4294967295 -> bin_out=32'hFFFFFFFF, overflow=0.
//     digits 4294967296 -> bin_out=0, overflow=1.
//  4. in3=4'hA (others 0) -> done 1 clk after start, error=1, bin_out=0, busy never asserted.
//  5. start pulsed again at +10 clk with different digits -> ignored; result matches the first operands; single done pulse.
//  6. reset asserted at +15 clk -> outputs 0 immediately (async); no done.
//     New start after release converts 99999999999 -> bin_out=32'h4876E7FF, overflow=1.

Source files
------------

// File: rtl/bcd_to_binary_32bits_pkg.sv
// Shared types and constants for the BCD <-> binary conversion paths.
// The packed BCD word type is common to both directions.
package bcd_to_binary_32bits_pkg;

    localparam int NUM_DIGITS  = 11;
    localparam int BIN_WIDTH   = 32;
    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_W       = NUM_DIGITS * BCD_DIGIT_W;
    localparam int CNT_W       = $clog2(BIN_WIDTH);

    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR      = 4'd3;

    typedef logic [BCD_W-1:0] bcd_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when any packed digit lies outside 0..9.
    function automatic logic has_bad_digit(input bcd_word_t word);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (word[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_to_binary_32bits_sub3.sv
// One digit of the reverse double-dabble correction: subtract 3 from
// any digit >= 8 after the right shift (inverse of the add-3 cell).
module bcd_digit_sub3
    import bcd_to_binary_32bits_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] corrected
);

    // A digit >= 8 stays >= 5 after correction, so this never underflows.
    assign corrected = (digit >= 4'd8) ? (digit - BCD_CORR) : digit;

endmodule

// File: rtl/bcd_to_binary_32bits.sv
// Iterative BCD-to-binary converter: 11 packed BCD digits in, 32-bit
// binary out, one shift per clock, with digit-range and overflow flags.
module bcd_to_binary_32bits
    import bcd_to_binary_32bits_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           in1,
    input  logic [3:0]           in2,
    input  logic [3:0]           in3,
    input  logic [3:0]           in4,
    input  logic [3:0]           in5,
    input  logic [3:0]           in6,
    input  logic [3:0]           in7,
    input  logic [3:0]           in8,
    input  logic [3:0]           in9,
    input  logic [3:0]           in10,
    input  logic [3:0]           in11,
    output logic [BIN_WIDTH-1:0] bin_out,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 overflow,
    output state_t               state_dbg
);

    // Handshake: start is sampled only in IDLE. An accepted start raises busy
    // until the final shift; done is a one-cycle pulse (DONE state) marking
    // bin_out/error/overflow valid. start seen in SHIFT or DONE is ignored.

    state_t                 state, state_next;
    bcd_word_t              digits;
    bcd_word_t              bcd_reg, bcd_shift, bcd_corr;
    logic [BIN_WIDTH-1:0]   bin_reg, bin_shift;
    logic [CNT_W-1:0]       cnt;
    logic                   digits_bad;
    logic                   last_shift;

    assign digits     = {in11, in10, in9, in8, in7, in6, in5, in4, in3, in2, in1};
    assign digits_bad = has_bad_digit(digits);
    assign last_shift = (cnt == CNT_W'(BIN_WIDTH - 1));

    // The BCD and binary registers form one long right shifter.
    assign bcd_shift = {1'b0, bcd_reg[BCD_W-1:1]};
    assign bin_shift = {bcd_reg[0], bin_reg[BIN_WIDTH-1:1]};

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_sub3
        bcd_digit_sub3 u_sub3 (
            .digit     (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .corrected (bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = digits_bad ? DONE : SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_reg  <= '0;
            bin_reg  <= '0;
            cnt      <= '0;
            bin_out  <= '0;
            busy     <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bcd_reg  <= digits;
                        bin_reg  <= '0;
                        cnt      <= '0;
                        error    <= digits_bad;
                        overflow <= 1'b0;
                        if (digits_bad) begin
                            bin_out <= '0;
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= bcd_corr;
                    bin_reg <= bin_shift;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        // Anything left in the BCD register is value / 2^32.
                        bin_out  <= bin_shift;
                        overflow <= (bcd_corr != '0);
                        busy     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_bcd_to_binary_32bits.sv
// Bench for bcd_to_binary_32bits: decimal reference model feeding an
// expected queue, checked whenever done pulses.
module tb_bcd_to_binary_32bits;
    import bcd_to_binary_32bits_pkg::*;

    localparam int EXP_W = 34;  // {error, overflow, bin[31:0]}

    logic        clk;
    logic        reset;
    logic        start;
    logic [43:0] din;
    logic [31:0] bin_out;
    logic        busy, done, error, overflow;
    state_t      state_dbg;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks;
    int n_pass;
    int done_cnt;

    bcd_to_binary_32bits dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in1       (din[3:0]),
        .in2       (din[7:4]),
        .in3       (din[11:8]),
        .in4       (din[15:12]),
        .in5       (din[19:16]),
        .in6       (din[23:20]),
        .in7       (din[27:24]),
        .in8       (din[31:28]),
        .in9       (din[35:32]),
        .in10      (din[39:36]),
        .in11      (din[43:40]),
        .bin_out   (bin_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: decimal evaluation of the digit vector.
    function automatic logic [EXP_W-1:0] model(input logic [43:0] bcd);
        logic [63:0] value;
        logic        bad;
        logic [3:0]  d;
        value = 64'd0;
        bad   = 1'b0;
        for (int i = 10; i >= 0; i--) begin
            d     = bcd[i*4 +: 4];
            bad   = bad | (d > 4'd9);
            value = value * 64'd10 + {60'd0, d};
        end
        if (bad) return {1'b1, 1'b0, 32'd0};
        return {1'b0, (value > 64'hFFFF_FFFF), value[31:0]};
    endfunction

    // Scoreboard: every done pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            logic [EXP_W-1:0] e;
            done_cnt++;
            check("exp_q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("bin_out",  {32'd0, bin_out},  {32'd0, e[31:0]});
                check("error",    {63'd0, error},    {63'd0, e[33]});
                check("overflow", {63'd0, overflow}, {63'd0, e[32]});
            end
        end
    end

    // Driver: one-cycle start pulse; push expectation; returns after start edge.
    task automatic drive_start(input logic [43:0] bcd);
        din   = bcd;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(model(bcd));
    endtask

    // Counts clocks from the start edge to done and busy-high cycles.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int lat;
        int busy_cycles;
        lat = -1;
        busy_cycles = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_busy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        n_checks = 0;
        n_pass   = 0;
        done_cnt = 0;
        reset    = 1'b0;
        start    = 1'b0;
        din      = '0;

        // 1. reset state, then zero conversion
        repeat (3) @(posedge clk);
        #1;
        check("rst_bin_out", {32'd0, bin_out}, 64'd0);
        check("rst_flags", {60'd0, busy, done, error, overflow}, 64'd0);
        check("rst_state", {62'd0, state_dbg}, {62'd0, IDLE});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_flags", {60'd0, busy, done, error, overflow}, 64'd0);
        drive_start(44'h000_0000_0000);
        wait_done("zero", 32, 32);

        // 2-3. main function and 32-bit boundary
        drive_start(44'h000_0001_2345);
        wait_done("d12345", 32, 32);
        drive_start(44'h042_9496_7295);
        wait_done("max32", 32, 32);
        drive_start(44'h042_9496_7296);
        wait_done("max32p1", 32, 32);
        for (int r = 0; r < 3; r++) begin
            logic [43:0] v;
            for (int i = 0; i < 11; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
            drive_start(v);
            wait_done("random", 32, 32);
        end

        // 4. invalid digit
        drive_start(44'h000_0000_0A00);
        wait_done("bad_digit", 0, 0);

        // 5. start mid-conversion is ignored; inputs not re-sampled
        n0 = done_cnt;
        drive_start(44'h009_8765_4321);
        repeat (9) @(posedge clk);
        #1;
        din   = 44'h000_0000_0777;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("ignored_start_done_count", 64'(done_cnt - n0), 64'd1);
        check("ignored_start_state", {62'd0, state_dbg}, {62'd0, IDLE});

        // 6. async reset mid-conversion abandons the result
        drive_start(44'h000_0005_4321);
        repeat (14) @(posedge clk);
        #3;
        n0 = done_cnt;
        reset = 1'b0;
        #1;
        check("async_rst_bin_out", {32'd0, bin_out}, 64'd0);
        check("async_rst_flags", {60'd0, busy, done, error, overflow}, 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abandoned_no_done", 64'(done_cnt - n0), 64'd0);
        drive_start(44'h999_9999_9999);
        wait_done("after_rst", 32, 32);

        repeat (2) @(posedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
